dma_priority_arbiter: RTL

Parametrised channel-priority and bus-request engine for the DMA controller, the next generation of the `priorityLogic` function. It arbitrates CHANNELS request lines and runs the HRQ/HLDA hold handshake with the CPU. It also drives DACK and tracks service in single, block or demand mode, with fixed or rotating priority. It sits between the bus pins and the timing/control engine, which reports transfer completion and EOP back to it.

---
 rtl/dma_priority_arbiter_pkg.sv | 34 +++
 rtl/dma_priority_arbiter_rotate_prio_enc.sv | 36 +++
 rtl/dma_priority_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dma_priority_arbiter_pkg.sv
// Shared configuration for the DMA priority arbiter: defaults, register
// codes, command bit positions and the state/mode encodings.
package dmaRegConfigPkg;

  localparam int CHANNELS  = 4;
  localparam int DATAWIDTH = 8;

  // Command register bit positions
  localparam int CMD_DISABLE   = 0;
  localparam int CMD_ROTATE    = 1;
  localparam int CMD_DREQ_LOW  = 2;
  localparam int CMD_DACK_HIGH = 3;

  // regSel write targets
  localparam logic [1:0] SEL_CMD   = 2'd0;
  localparam logic [1:0] SEL_MASK  = 2'd1;
  localparam logic [1:0] SEL_MODE  = 2'd2;
  localparam logic [1:0] SEL_SWREQ = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  typedef enum logic [1:0] {
    MODE_DEMAND   = 2'd0,
    MODE_SINGLE   = 2'd1,
    MODE_BLOCK    = 2'd2,
    MODE_RESERVED = 2'd3
  } mode_t;

  // The reserved mode code behaves exactly like single mode
  function automatic logic is_single(input mode_t m);
    return (m == MODE_SINGLE) || (m == MODE_RESERVED);
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_rotate_prio_enc.sv
// Rotating priority encoder: the channel at ptr has highest priority and
// priority decreases upward with wrap-around. Purely combinational.
module dma_rotate_prio_enc #(
  parameter int CHANNELS = 4,
  localparam int CW = $clog2(CHANNELS)
) (
  input  logic [CW-1:0]       ptr,
  input  logic [CHANNELS-1:0] req,
  output logic [CW-1:0]       winner,
  output logic                valid
);

  localparam logic [CW:0] NCH = (CW+1)'(CHANNELS);

  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic [CW-1:0]         offset;
  logic [CW:0]           sum;

  // Rotate the request vector so bit 0 is the channel at ptr
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[CHANNELS-1:0];

  // Lowest set bit of the rotated vector is the winner's distance from ptr
  always_comb begin
    offset = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (rot[k]) offset = CW'(k);
    end
  end

  assign valid  = |req;
  assign sum    = {1'b0, ptr} + {1'b0, offset};
  assign winner = (sum >= NCH) ? CW'(sum - NCH) : CW'(sum);

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: register file, request qualification, priority
// selection and the HRQ/HLDA/DACK hold handshake.
module dma_priority_arbiter
  import dmaRegConfigPkg::*;
#(
  parameter int CHANNELS  = dmaRegConfigPkg::CHANNELS,
  parameter int DATAWIDTH = dmaRegConfigPkg::DATAWIDTH,
  localparam int CW = $clog2(CHANNELS)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [CHANNELS-1:0]  DREQ,
  input  logic                 HLDA,
  input  logic                 xferDone,
  input  logic                 eop,
  input  logic                 regWe,
  input  logic [1:0]           regSel,
  input  logic [DATAWIDTH-1:0] regWdata,
  output logic                 HRQ,
  output logic [CHANNELS-1:0]  DACK,
  output logic [CW-1:0]        activeChannel,
  output logic                 busy
);

  state_t              state_reg, state_next;
  logic [3:0]          cmd_reg;
  logic [CHANNELS-1:0] mask_reg, swreq_reg, autoinit_reg;
  mode_t               mode_reg [CHANNELS];
  logic [CW-1:0]       ptr_reg, active_reg;

  logic [CHANNELS-1:0] hw_req, eff_req, grant_vec;
  logic [CW-1:0]       enc_ptr, winner, wr_ch;
  logic                win_valid, wr_bit, rot_en, service_end;
  mode_t               wr_mode, cur_mode;

  assign wr_ch   = regWdata[CW-1:0];
  assign wr_bit  = regWdata[CW];
  assign wr_mode = mode_t'(regWdata[CW+1:CW]);

  generate
    if (DATAWIDTH > CW + 3) begin : g_spare_bits
      logic unused_wdata;
      assign unused_wdata = ^regWdata[DATAWIDTH-1:CW+3];
    end
  endgenerate

  assign hw_req   = cmd_reg[CMD_DREQ_LOW] ? ~DREQ : DREQ;
  assign eff_req  = (hw_req | swreq_reg) & ~mask_reg & {CHANNELS{~cmd_reg[CMD_DISABLE]}};
  assign rot_en   = cmd_reg[CMD_ROTATE];
  assign enc_ptr  = rot_en ? ptr_reg : '0;
  assign cur_mode = mode_reg[active_reg];

  dma_rotate_prio_enc #(.CHANNELS(CHANNELS)) u_enc (
    .ptr    (enc_ptr),
    .req    (eff_req),
    .winner (winner),
    .valid  (win_valid)
  );

  // eop ends any mode; xferDone ends single mode, a masked channel, or demand
  // mode once the hardware request has gone away
  assign service_end = eop | (xferDone & (is_single(cur_mode) | mask_reg[active_reg] |
                       ((cur_mode == MODE_DEMAND) & ~hw_req[active_reg])));

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; HLDA loss in GRANT aborts straight back to IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|eff_req) state_next = REQ;
      REQ:     if (!win_valid) state_next = RELEASE;
               else if (HLDA)  state_next = GRANT;
      GRANT:   if (!HLDA)           state_next = IDLE;
               else if (service_end) state_next = RELEASE;
      RELEASE: if (!HLDA) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    grant_vec = '0;
    if (state_reg == GRANT) grant_vec[active_reg] = 1'b1;
    HRQ  = (state_reg == REQ) || (state_reg == GRANT);
    busy = (state_reg != IDLE);
  end

  assign DACK          = cmd_reg[CMD_DACK_HIGH] ? grant_vec : ~grant_vec;
  assign activeChannel = active_reg;

  // Latch the winner at grant; advance the rotate pointer past a finished channel
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      active_reg <= '0;
      ptr_reg    <= '0;
    end else begin
      if (state_reg == REQ && state_next == GRANT) active_reg <= winner;
      if (state_reg == GRANT && state_next == RELEASE && rot_en)
        ptr_reg <= (active_reg == CW'(CHANNELS - 1)) ? '0 : active_reg + 1'b1;
    end
  end

  // Register file; eop side effects first so a same-cycle write overrides them
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cmd_reg      <= '0;
      mask_reg     <= '1;
      swreq_reg    <= '0;
      autoinit_reg <= '0;
      for (int i = 0; i < CHANNELS; i++) mode_reg[i] <= MODE_DEMAND;
    end else begin
      if (state_reg == GRANT && eop) begin
        swreq_reg[active_reg] <= 1'b0;
        if (!autoinit_reg[active_reg]) mask_reg[active_reg] <= 1'b1;
      end
      if (regWe) begin
        case (regSel)
          SEL_CMD:   if (state_reg == IDLE) cmd_reg <= regWdata[3:0];
          SEL_MASK:  mask_reg[wr_ch] <= wr_bit;
          SEL_MODE: begin
            mode_reg[wr_ch]     <= wr_mode;
            autoinit_reg[wr_ch] <= regWdata[CW+2];
          end
          SEL_SWREQ: swreq_reg[wr_ch] <= wr_bit;
          default: ;
        endcase
      end
    end
  end

endmodule
